fifo_burst_reader: RTL and testbench

//  Read-side companion of the FIFO: drains a programmed burst of words from the FIFO
//  (data_out/empty/shift_out interface) and presents them on a valid/ready stream.

---
 rtl/fifo_burst_reader.sv | 95 +++++++++
 tb/tb_fifo_burst_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst of words from a FIFO read port onto a valid/ready stream,
// through a 2-entry in-order buffer, tracking a per-burst word count and XOR checksum.
module fifo_burst_reader #(
  parameter int DATA = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DATA-1:0] fifo_data,
  input  logic            fifo_empty,
  output logic            fifo_shift_out,
  input  logic            start,
  input  logic [CNTW-1:0] burst_len,
  output logic [DATA-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] word_count,
  output logic [DATA-1:0] checksum
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] pop_left;
  logic [1:0]      buf_cnt;
  logic [DATA-1:0] buf_head, buf_tail;
  logic            transfer, pop, accept;

  assign transfer       = m_valid & m_ready;
  assign accept         = (state == S_IDLE) & start;
  assign pop            = (state == S_RUN) & ~fifo_empty & (pop_left != '0) &
                          ((buf_cnt < 2'd2) | transfer);
  assign fifo_shift_out = pop;
  assign m_valid        = (buf_cnt != 2'd0);
  assign m_data         = m_valid ? buf_head : '0;
  assign busy           = (state == S_RUN) | (state == S_FLUSH);
  assign done           = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (burst_len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (pop && pop_left == CNTW'(1)) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // No pops happen here, so the burst ends when the last buffered word leaves.
        if (transfer && buf_cnt == 2'd1) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pop_left   <= '0;
      buf_cnt    <= 2'd0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)   pop_left <= burst_len;
      else if (pop) pop_left <= pop_left - CNTW'(1);
      case ({pop, transfer})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
      if (accept) begin
        word_count <= '0;
        checksum   <= '0;
      end else if (transfer) begin
        word_count <= word_count + CNTW'(1);
        checksum   <= checksum ^ m_data;
      end
    end
  end

  // Buffer payload needs no reset: buf_cnt alone decides what is visible.
  always_ff @(posedge clk) begin
    if (pop && (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && transfer)))
      buf_head <= fifo_data;
    else if (transfer)
      buf_head <= buf_tail;
    if (pop && ((buf_cnt == 2'd1 && !transfer) || buf_cnt == 2'd2))
      buf_tail <= fifo_data;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: an array-backed FIFO feeds the DUT, a negedge monitor logs
// pops, transfers and done pulses, and each scenario task compares against a word queue model.
module tb_fifo_burst_reader;
  localparam int DATA = 32;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [DATA-1:0] fifo_data;
  logic            fifo_empty;
  logic            fifo_shift_out;
  logic            start;
  logic [CNTW-1:0] burst_len;
  logic [DATA-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] word_count;
  logic [DATA-1:0] checksum;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA(DATA), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_shift_out(fifo_shift_out), .start(start), .burst_len(burst_len),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
    .word_count(word_count), .checksum(checksum)
  );

  // Bench-side FIFO: written by the stimulus process, popped on the DUT's request.
  logic [DATA-1:0] mem [0:1023];
  logic [9:0]      wr_ptr = '0;
  logic [9:0]      rd_ptr = '0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_empty ? '0 : mem[rd_ptr];
  always @(posedge clk) if (fifo_shift_out && !fifo_empty) rd_ptr <= rd_ptr + 10'd1;

  int              cyc = 0, pop_cnt = 0, done_cnt = 0, uflow = 0;
  int              pop_cyc[$];
  logic [DATA-1:0] out_q[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_shift_out) begin
      pop_cnt <= pop_cnt + 1;
      pop_cyc.push_back(cyc);
      if (fifo_empty) uflow <= uflow + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (m_valid && m_ready && reset) out_q.push_back(m_data);
  end

  int              total = 0, bad = 0;
  logic [DATA-1:0] ref_q[$];
  logic [DATA-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DATA-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 10'd1;
    ref_q.push_back(w);
  endtask

  task automatic go(input int len);
    tick(); start = 1'b1; burst_len = CNTW'(len);
    tick(); start = 1'b0;
  endtask

  // Model: a burst of n delivers the next n words pushed into the FIFO, in order.
  task automatic expect_words(input int n);
    exp_q.delete();
    repeat (n) exp_q.push_back(ref_q.pop_front());
  endtask

  function automatic logic [DATA-1:0] exp_xor();
    logic [DATA-1:0] x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    return x;
  endfunction

  task automatic wait_done(input int budget, input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    tick(); tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", m_valid); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL rst_data: got %0h want 0", m_data); end
    total++; if (fifo_shift_out !== 1'b0) begin bad++; $display("FAIL rst_pop: got %b want 0", fifo_shift_out); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    total++; if (word_count !== '0 || checksum !== '0) begin bad++; $display("FAIL rst_counters: got %0d/%0h want 0/0", word_count, checksum); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int p0, pc0, o0, d0; bit ok; bit consec;
    push(32'h11); push(32'h22); push(32'h33);
    expect_words(3);
    m_ready = 1'b1;
    p0 = pop_cnt; pc0 = pop_cyc.size(); o0 = out_q.size(); d0 = done_cnt;
    go(3);
    wait_done(30, d0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout: got none want done"); end
    total++; if (word_count !== CNTW'(3)) begin bad++; $display("FAIL basic_count: got %0d want 3", word_count); end
    total++; if (checksum !== exp_xor()) begin bad++; $display("FAIL basic_checksum: got %0h want %0h", checksum, exp_xor()); end
    total++; if (out_q.size() - o0 !== 3) begin bad++; $display("FAIL basic_len: got %0d want 3", out_q.size() - o0); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (out_q[o0+i] !== exp_q[i]) begin bad++; $display("FAIL basic_word%0d: got %0h want %0h", i, out_q[o0+i], exp_q[i]); end
    end
    consec = (pop_cnt - p0 == 3) && (pop_cyc[pc0+1] == pop_cyc[pc0] + 1) && (pop_cyc[pc0+2] == pop_cyc[pc0] + 2);
    total++; if (!consec) begin bad++; $display("FAIL basic_pops: got %0d pops consec=%b want 3 consec=1", pop_cnt - p0, consec); end
    tick(); tick(); tick();
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_width: got %0d want 1", done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int p0, o0, d0; bit ok;
    for (int i = 0; i < 4; i++) push(32'hA0 + DATA'(i));
    expect_words(4);
    m_ready = 1'b0;
    p0 = pop_cnt; o0 = out_q.size(); d0 = done_cnt;
    go(4);
    repeat (10) tick();
    total++; if (pop_cnt - p0 !== 2) begin bad++; $display("FAIL stall_pops: got %0d want 2", pop_cnt - p0); end
    total++; if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin bad++; $display("FAIL stall_hold: got %b/%0h want 1/%0h", m_valid, m_data, exp_q[0]); end
    total++; if (fifo_shift_out !== 1'b0) begin bad++; $display("FAIL stall_nopop: got %b want 0", fifo_shift_out); end
    m_ready = 1'b1;
    wait_done(30, d0, ok);
    total++; if (!ok || out_q.size() - o0 !== 4) begin bad++; $display("FAIL stall_done_after4: got ok=%b n=%0d want ok=1 n=4", ok, out_q.size() - o0); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (out_q[o0+i] !== exp_q[i]) begin bad++; $display("FAIL stall_word%0d: got %0h want %0h", i, out_q[o0+i], exp_q[i]); end
    end
    total++; if (word_count !== CNTW'(4)) begin bad++; $display("FAIL stall_count: got %0d want 4", word_count); end
    tick(); tick();
  endtask

  task automatic test_starve();
    int o0, d0; bit ok;
    push(32'h5); push(32'h6);
    m_ready = 1'b1;
    o0 = out_q.size(); d0 = done_cnt;
    go(5);
    repeat (8) tick();
    total++; if (out_q.size() - o0 !== 2) begin bad++; $display("FAIL starve_partial: got %0d want 2", out_q.size() - o0); end
    total++; if (busy !== 1'b1 || fifo_shift_out !== 1'b0) begin bad++; $display("FAIL starve_wait: got busy=%b pop=%b want 1/0", busy, fifo_shift_out); end
    total++; if (uflow !== 0 || done_cnt !== d0) begin bad++; $display("FAIL starve_uflow_done: got %0d/%0d want 0/0", uflow, done_cnt - d0); end
    push(32'h7); push(32'h8); push(32'h9);
    expect_words(5);
    wait_done(30, d0, ok);
    total++; if (!ok || word_count !== CNTW'(5)) begin bad++; $display("FAIL starve_count: got ok=%b n=%0d want ok=1 n=5", ok, word_count); end
    total++; if (checksum !== exp_xor()) begin bad++; $display("FAIL starve_checksum: got %0h want %0h", checksum, exp_xor()); end
    tick(); tick();
  endtask

  task automatic test_zero();
    int p0, d0;
    p0 = pop_cnt; d0 = done_cnt;
    go(0);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); end
    total++; if (word_count !== '0 || checksum !== '0) begin bad++; $display("FAIL zero_counters: got %0d/%0h want 0/0", word_count, checksum); end
    tick();
    total++; if (done !== 1'b0 || done_cnt - d0 !== 1) begin bad++; $display("FAIL zero_pulse: got done=%b pulses=%0d want 0/1", done, done_cnt - d0); end
    total++; if (pop_cnt !== p0) begin bad++; $display("FAIL zero_nopop: got %0d want 0", pop_cnt - p0); end
  endtask

  task automatic test_abort();
    int p0, o0, d0; bit ok;
    for (int i = 0; i < 6; i++) push(32'hC0 + DATA'(i));
    expect_words(3);
    m_ready = 1'b0;
    p0 = pop_cnt; o0 = out_q.size(); d0 = done_cnt;
    go(6);
    repeat (3) tick();
    m_ready = 1'b1; tick();
    m_ready = 1'b0; repeat (4) tick();
    total++; if (pop_cnt - p0 !== 3 || m_valid !== 1'b1) begin bad++; $display("FAIL abort_setup: got pops=%0d valid=%b want 3/1", pop_cnt - p0, m_valid); end
    total++; if (out_q.size() - o0 !== 1 || word_count !== CNTW'(1) || checksum !== exp_q[0]) begin bad++; $display("FAIL abort_pre: got n=%0d cnt=%0d sum=%0h want 1/1/%0h", out_q.size() - o0, word_count, checksum, exp_q[0]); end
    #2 reset = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0 || m_data !== '0 || fifo_shift_out !== 1'b0) begin bad++; $display("FAIL abort_async_out: got %b/%0h/%b want 0/0/0", m_valid, m_data, fifo_shift_out); end
    total++; if (busy !== 1'b0 || word_count !== '0 || checksum !== '0) begin bad++; $display("FAIL abort_async_state: got %b/%0d/%0h want 0/0/0", busy, word_count, checksum); end
    tick(); tick();
    total++; if (pop_cnt - p0 !== 3 || done_cnt !== d0) begin bad++; $display("FAIL abort_untouched: got pops=%0d done=%0d want 3/0", pop_cnt - p0, done_cnt - d0); end
    reset = 1'b1;
    tick();
    expect_words(3);
    m_ready = 1'b1;
    o0 = out_q.size(); d0 = done_cnt;
    go(3);
    wait_done(30, d0, ok);
    total++; if (!ok || out_q.size() - o0 !== 3 || word_count !== CNTW'(3)) begin bad++; $display("FAIL abort_restart: got ok=%b n=%0d cnt=%0d want 1/3/3", ok, out_q.size() - o0, word_count); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (out_q[o0+i] !== exp_q[i]) begin bad++; $display("FAIL abort_word%0d: got %0h want %0h", i, out_q[o0+i], exp_q[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_random();
    int p0, o0, d0, nerr; bit ok;
    for (int i = 0; i < 200; i++) push(DATA'($urandom));
    expect_words(200);
    p0 = pop_cnt; o0 = out_q.size(); d0 = done_cnt; nerr = 0;
    go(200);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      if ((i == 10 || i == 60 || i == 150) && busy) begin start = 1'b1; burst_len = CNTW'(3); end
      else start = 1'b0;
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
    start = 1'b0; m_ready = 1'b1;
    repeat (4) tick();
    total++; if (!ok) begin bad++; $display("FAIL rand_timeout: got none want done"); end
    total++; if (out_q.size() - o0 !== 200) begin bad++; $display("FAIL rand_len: got %0d want 200", out_q.size() - o0); end
    else begin
      for (int i = 0; i < 200; i++) if (out_q[o0+i] !== exp_q[i]) nerr++;
      total++; if (nerr !== 0) begin bad++; $display("FAIL rand_order: got %0d wrong words want 0", nerr); end
    end
    total++; if (checksum !== exp_xor()) begin bad++; $display("FAIL rand_checksum: got %0h want %0h", checksum, exp_xor()); end
    total++; if (word_count !== CNTW'(200)) begin bad++; $display("FAIL rand_count: got %0d want 200", word_count); end
    total++; if (pop_cnt - p0 !== 200 || done_cnt - d0 !== 1 || busy !== 1'b0) begin bad++; $display("FAIL rand_ignore_start: got pops=%0d dones=%0d busy=%b want 200/1/0", pop_cnt - p0, done_cnt - d0, busy); end
    total++; if (uflow !== 0) begin bad++; $display("FAIL rand_underflow: got %0d want 0", uflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_starve();
    test_zero();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
